// File: rtl/alu_bit_serial_sequencer.sv
// Drives one external 1-bit ALU cell through a WIDTH-bit operation, LSB first,
// keeping the operand, carry and result state here and handshaking with start/done.
module alu_bit_serial_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       fs,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in0,
    input  logic             fill_msb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             zero,
    output logic [4:0]       cell_fs,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_c_in,
    output logic             cell_a_next,
    input  logic             cell_f,
    input  logic             cell_c_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [4:0]       fs_q;
    logic             fill_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    assign last_bit = (cnt == LAST_BIT);
    assign res_next = {cell_f, res_sh[WIDTH-1:1]};

    // The MSB step has no higher operand bit, so the shift-right fill stands in for it.
    assign cell_fs     = fs_q;
    assign cell_a      = a_sh[0];
    assign cell_b      = b_sh[0];
    assign cell_c_in   = carry;
    assign cell_a_next = last_bit ? fill_q : a_sh[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            f      <= '0;
            c_out  <= 1'b0;
            zero   <= 1'b1;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            fs_q   <= '0;
            fill_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        a_sh   <= a;
                        b_sh   <= b;
                        fs_q   <= fs;
                        fill_q <= fill_msb;
                        carry  <= c_in0;
                        cnt    <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    res_sh <= res_next;
                    carry  <= cell_c_out;
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    // Counter parks on the last bit rather than wrapping.
                    if (last_bit) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        f     <= res_next;
                        zero  <= (res_next == '0);
                        c_out <= fs_q[4] & cell_c_out;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// Bench for alu_bit_serial_sequencer: models the 1-bit cell, runs table vectors,
// hand-written handshake/reset sequences and random ops against a word-level model.
module tb_alu_bit_serial_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [4:0]       fs;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in0;
    logic             fill_msb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             zero;
    logic [4:0]       cell_fs;
    logic             cell_a;
    logic             cell_b;
    logic             cell_c_in;
    logic             cell_a_next;
    logic             cell_f;
    logic             cell_c_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_bit_serial_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fs         (fs),
        .a          (a),
        .b          (b),
        .c_in0      (c_in0),
        .fill_msb   (fill_msb),
        .busy       (busy),
        .done       (done),
        .f          (f),
        .c_out      (c_out),
        .zero       (zero),
        .cell_fs    (cell_fs),
        .cell_a     (cell_a),
        .cell_b     (cell_b),
        .cell_c_in  (cell_c_in),
        .cell_a_next(cell_a_next),
        .cell_f     (cell_f),
        .cell_c_out (cell_c_out)
    );

    // 1-bit cell; logic ops drive C_out = A so the sequencer must mask it.
    always_comb begin
        cell_f     = 1'b0;
        cell_c_out = 1'b0;
        casez (cell_fs)
            5'b00000: begin cell_f = cell_a;           cell_c_out = cell_a; end
            5'b00010: begin cell_f = cell_a | cell_b;  cell_c_out = cell_a; end
            5'b00100: begin cell_f = ~cell_a;          cell_c_out = cell_a; end
            5'b00110: begin cell_f = cell_a ^ cell_b;  cell_c_out = cell_a; end
            5'b01000: begin cell_f = cell_a & cell_b;  cell_c_out = cell_a; end
            5'b10000: {cell_c_out, cell_f} = {1'b0, cell_a} + {1'b0, cell_c_in};
            5'b10010: {cell_c_out, cell_f} = {1'b0, cell_a} + {1'b0, ~cell_b} + {1'b0, cell_c_in};
            5'b10100: {cell_c_out, cell_f} = {1'b0, cell_a} + {1'b0, cell_b} + {1'b0, cell_c_in};
            5'b11??0: begin cell_f = cell_c_in;   cell_c_out = cell_a; end
            5'b11??1: begin cell_f = cell_a_next; cell_c_out = cell_a; end
            default: ;
        endcase
    end

    function automatic void refModel(input logic [4:0] op, input logic [WIDTH-1:0] av,
                                     input logic [WIDTH-1:0] bv, input logic ci, input logic fl,
                                     output logic [WIDTH-1:0] rf, output logic rc);
        logic [WIDTH:0] wide;
        rf = '0;
        rc = 1'b0;
        casez (op)
            5'b00000: rf = av;
            5'b00010: rf = av | bv;
            5'b00100: rf = ~av;
            5'b00110: rf = av ^ bv;
            5'b01000: rf = av & bv;
            5'b10000: begin wide = {1'b0, av} + (WIDTH+1)'(ci);                        {rc, rf} = wide; end
            5'b10010: begin wide = {1'b0, av} + {1'b0, ~bv} + (WIDTH+1)'(ci);          {rc, rf} = wide; end
            5'b10100: begin wide = {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(ci);           {rc, rf} = wide; end
            5'b11??0: begin rf = {av[WIDTH-2:0], ci}; rc = av[WIDTH-1]; end
            5'b11??1: begin rf = {fl, av[WIDTH-1:1]}; rc = av[WIDTH-1]; end
            default: ;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic ci, input logic fl);
        fs       = op;
        a        = av;
        b        = bv;
        c_in0    = ci;
        fill_msb = fl;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen, bounded.
    task automatic waitDone(output int edges, output int busy_cycles, output bit seen);
        edges       = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic runOp(input string name, input logic [4:0] op, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic ci, input logic fl,
                         input logic [WIDTH-1:0] exp_f, input logic exp_c, input logic exp_z);
        int edges, busy_cycles;
        bit seen;
        applyStimulus(op, av, bv, ci, fl);
        waitDone(edges, busy_cycles, seen);
        checkOutput({name, "_done"}, 32'(seen), 32'd1);
        checkOutput({name, "_latency"}, edges, WIDTH);
        checkOutput({name, "_busy"}, busy_cycles, WIDTH);
        checkOutput({name, "_f"}, exp_f, f);
        checkOutput({name, "_c"}, 32'(c_out), 32'(exp_c));
        checkOutput({name, "_z"}, 32'(zero), 32'(exp_z));
    endtask

    typedef struct {
        logic [4:0]       op;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             ci;
        logic             fl;
        logic [WIDTH-1:0] ef;
        logic             ec;
        logic             ez;
    } vec_t;

    vec_t       vecs[10];
    logic [4:0] codes[12];

    initial begin
        int edges, busy_cycles;
        bit seen;
        bit saw_done;
        logic [WIDTH-1:0] rf;
        logic rc;

        vecs[0] = '{5'b10100, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{5'b10100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{5'b00110, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0};
        vecs[3] = '{5'b01000, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b0};
        vecs[4] = '{5'b11000, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{5'b11001, 16'h8001, 16'h0000, 1'b0, 1'b1, 16'hC000, 1'b1, 1'b0};
        vecs[6] = '{5'b10010, 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[7] = '{5'b11001, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[8] = '{5'b11000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{5'b10000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};

        codes = '{5'b00000, 5'b00010, 5'b00100, 5'b00110, 5'b01000, 5'b10000,
                  5'b10010, 5'b10100, 5'b11000, 5'b11010, 5'b11001, 5'b11101};

        rst_n    = 1'b0;
        start    = 1'b0;
        fs       = '0;
        a        = '0;
        b        = '0;
        c_in0    = 1'b0;
        fill_msb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_f", 32'(f), 32'd0);
        checkOutput("reset_c", 32'(c_out), 32'd0);
        checkOutput("reset_z", 32'(zero), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++)
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].av, vecs[i].bv,
                  vecs[i].ci, vecs[i].fl, vecs[i].ef, vecs[i].ec, vecs[i].ez);

        // done is a single-cycle pulse and f holds into IDLE
        @(posedge clk);
        #1;
        checkOutput("pulse_done", 32'(done), 32'd0);
        checkOutput("pulse_busy", 32'(busy), 32'd0);
        checkOutput("hold_f", 32'(f), 32'h0000);

        // back-to-back start in the done cycle
        runOp("b2b_first", 5'b00110, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0);
        applyStimulus(5'b01000, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_f_held", 32'(f), 32'h0FF0);
        waitDone(edges, busy_cycles, seen);
        checkOutput("b2b_latency", edges, WIDTH);
        checkOutput("b2b_f", 32'(f), 32'hF000);

        // start during RUN with new operands is ignored
        applyStimulus(5'b10100, 16'h1234, 16'h1111, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        fs    = 5'b00000;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(edges, busy_cycles, seen);
        checkOutput("ignore_latency", edges + 6, WIDTH);
        checkOutput("ignore_f", 32'(f), 32'h2345);
        @(posedge clk);
        #1;
        checkOutput("ignore_no_rerun", 32'(busy), 32'd0);

        // asynchronous reset in the middle of an operation
        applyStimulus(5'b10100, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_f", 32'(f), 32'd0);
        checkOutput("abort_z", 32'(zero), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(saw_done), 32'd0);
        runOp("after_abort", 5'b10100, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // random operations against the word-level model
        for (int n = 0; n < 40; n++) begin
            logic [4:0]       op;
            logic [WIDTH-1:0] av, bv;
            logic             ci, fl;
            op = codes[$urandom_range(0, 11)];
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            ci = 1'($urandom);
            fl = 1'($urandom);
            refModel(op, av, bv, ci, fl, rf, rc);
            runOp($sformatf("rand%0d_fs%b", n, op), op, av, bv, ci, fl, rf, rc, (rf == '0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
